// File: rtl/hdmi_yc422_packer.sv
// YCbCr 4:4:4 -> 4:2:2 packer for the ADV7511 16-bit bus, with active-line length measurement.
// Fixed 3-clock latency on de/hs/vs/data; one pixel per clock, never stalls.
module hdmi_yc422_packer #(
    parameter int          FILTER  = 1,
    parameter logic [7:0]  BLANK_Y = 8'h10,
    parameter logic [7:0]  BLANK_C = 8'h80
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [23:0] in_data,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [15:0] out_data,
    output logic [11:0] line_len,
    output logic        odd_line,
    input  logic        clr_odd
);

    logic        s1_de_q, s1_hs_q, s1_vs_q, s1_odd_q;
    logic [23:0] s1_dat_q;
    logic        s2_de_q, s2_hs_q, s2_vs_q, s2_odd_q;
    logic [23:0] s2_dat_q;
    logic [7:0]  prev_cr_q;
    logic        out_de_q, out_hs_q, out_vs_q;
    logic [15:0] out_dat_q, out_dat_d;
    logic        phase_q, phase_d, pix_odd;
    logic [11:0] cnt_q, cnt_d, line_len_q, line_len_d;
    logic        odd_q, odd_d;
    logic        de_fall;
    logic [8:0]  sum_cb, sum_cr;
    logic [7:0]  chroma;

    // A rising DE forces the incoming pixel to EVEN; the phase then toggles per active pixel.
    always_comb begin
        pix_odd = (in_de && !s1_de_q) ? 1'b0 : phase_q;
        phase_d = in_de ? ~pix_odd : phase_q;
    end

    // Stage 2 sees pixel k, stage 1 already holds k+1 (or blanking when k is the last pixel).
    always_comb begin
        sum_cb = {1'b0, s2_dat_q[15:8]} + {1'b0, s1_dat_q[15:8]} + 9'd1;
        sum_cr = {1'b0, prev_cr_q} + {1'b0, s2_dat_q[7:0]} + 9'd1;
        chroma = s2_dat_q[15:8];
        if (FILTER == 0) begin
            chroma = s2_odd_q ? s2_dat_q[7:0] : s2_dat_q[15:8];
        end else if (s2_odd_q) begin
            chroma = sum_cr[8:1];
        end else if (s1_de_q) begin
            chroma = sum_cb[8:1];
        end
        out_dat_d = s2_de_q ? {chroma, s2_dat_q[23:16]} : {BLANK_C, BLANK_Y};
    end

    always_comb begin
        de_fall    = !in_de && s1_de_q;
        cnt_d      = cnt_q;
        line_len_d = line_len_q;
        odd_d      = odd_q;
        if (de_fall) begin
            cnt_d      = 12'd0;
            line_len_d = cnt_q;
        end else if (in_de && cnt_q != 12'hFFF) begin
            cnt_d = cnt_q + 12'd1;
        end
        if (clr_odd) begin
            odd_d = 1'b0;
        end
        if (de_fall && cnt_q[0]) begin
            odd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_de_q    <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_odd_q   <= 1'b0;
            s1_dat_q   <= 24'd0;
            s2_de_q    <= 1'b0;
            s2_hs_q    <= 1'b0;
            s2_vs_q    <= 1'b0;
            s2_odd_q   <= 1'b0;
            s2_dat_q   <= 24'd0;
            prev_cr_q  <= 8'd0;
            out_de_q   <= 1'b0;
            out_hs_q   <= 1'b0;
            out_vs_q   <= 1'b0;
            out_dat_q  <= {BLANK_C, BLANK_Y};
            phase_q    <= 1'b0;
            cnt_q      <= 12'd0;
            line_len_q <= 12'd0;
            odd_q      <= 1'b0;
        end else begin
            s1_de_q    <= in_de;
            s1_hs_q    <= in_hs;
            s1_vs_q    <= in_vs;
            s1_odd_q   <= pix_odd;
            s1_dat_q   <= in_data;
            s2_de_q    <= s1_de_q;
            s2_hs_q    <= s1_hs_q;
            s2_vs_q    <= s1_vs_q;
            s2_odd_q   <= s1_odd_q;
            s2_dat_q   <= s1_dat_q;
            prev_cr_q  <= s2_dat_q[7:0];
            out_de_q   <= s2_de_q;
            out_hs_q   <= s2_hs_q;
            out_vs_q   <= s2_vs_q;
            out_dat_q  <= out_dat_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            line_len_q <= line_len_d;
            odd_q      <= odd_d;
        end
    end

    assign out_de   = out_de_q;
    assign out_hs   = out_hs_q;
    assign out_vs   = out_vs_q;
    assign out_data = out_dat_q;
    assign line_len = line_len_q;
    assign odd_line = odd_q;

endmodule
